// File: rtl/nios2_pio_pkg.sv
// Shared definitions for the switch-input PIO: register offsets,
// edge-capture modes and a counter sizing helper.
package nios2_pio_pkg;

  typedef enum logic [1:0] {
    DATA     = 2'd0,
    RESERVED = 2'd1,
    IRQMASK  = 2'd2,
    EDGECAP  = 2'd3
  } reg_addr_e;

  typedef enum int {
    RISING  = 0,
    FALLING = 1,
    ANY     = 2
  } edge_type_e;

  // Width of a counter that must hold values 0..d; never narrower than 1 bit.
  function automatic int cnt_width(input int d);
    return (d < 1) ? 1 : $clog2(d + 1);
  endfunction

endpackage

// File: rtl/nios2_system_sw_pio_irq_bit.sv
// One input bit: synchroniser chain, optional debounce counter, the
// accepted (stable) value and a single-cycle edge pulse that coincides
// with the edge on which the stable value changes.
module pio_debounce_bit
  import nios2_pio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_in,
  output logic o_stable,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic                   r_stable;
  logic                   w_stable_nxt;
  logic                   w_rise;
  logic                   w_fall;

  // Metastability chain for the asynchronous switch input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_nodb
      assign w_stable_nxt = w_sync;
    end else begin : g_db
      localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] r_cnt;
      logic [CW-1:0] w_cnt_nxt;
      logic          w_accept;

      // Count consecutive disagreeing samples; accept on the D-th one.
      always_comb begin
        w_accept  = 1'b0;
        w_cnt_nxt = '0;
        if (w_sync != r_stable) begin
          if (r_cnt == LAST) w_accept = 1'b1;
          else               w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      // Debounce counter register.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_cnt <= '0;
        else          r_cnt <= w_cnt_nxt;
      end

      assign w_stable_nxt = w_accept ? w_sync : r_stable;
    end
  endgenerate

  // Accepted input value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_stable <= 1'b0;
    else          r_stable <= w_stable_nxt;
  end

  assign w_rise = w_stable_nxt & ~r_stable;
  assign w_fall = ~w_stable_nxt & r_stable;

  // Edge pulse selected by capture mode, aligned with the stable update.
  always_comb begin
    if (EDGE_TYPE == int'(RISING))       o_edge = w_rise;
    else if (EDGE_TYPE == int'(FALLING)) o_edge = w_fall;
    else                                 o_edge = w_rise | w_fall;
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/nios2_system_sw_pio_irq.sv
// Avalon-MM input PIO with per-bit debounce, interrupt mask, sticky
// edge capture (write-1-to-clear) and a registered level interrupt.
module nios2_system_sw_pio_irq
  import nios2_pio_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd_nxt;
  logic [31:0]      r_rd;
  logic             r_irq;
  logic             w_wr;
  logic             w_unused_wdata;

  // Upper writedata bits have no destination when WIDTH < 32.
  assign w_unused_wdata = ^writedata;

  assign w_wr = chipselect & ~write_n;

  generate
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      pio_debounce_bit #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .EDGE_TYPE      (EDGE_TYPE)
      ) u_bit (
        .clk     (clk),
        .reset_n (reset_n),
        .i_in    (in_port[g]),
        .o_stable(w_stable[g]),
        .o_edge  (w_edge[g])
      );
    end
  endgenerate

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                   r_mask <= '0;
    else if (w_wr && reg_addr_e'(address) == IRQMASK) r_mask <= writedata[WIDTH-1:0];
  end

  // Bits cleared by a write-1-to-clear access this cycle.
  always_comb begin
    w_clr = '0;
    if (w_wr && reg_addr_e'(address) == EDGECAP) w_clr = writedata[WIDTH-1:0];
  end

  // Sticky edge capture; a new edge overrides a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_cap <= '0;
    else          r_cap <= (r_cap & ~w_clr) | w_edge;
  end

  // Free-running read mux, zero-extended to the bus width.
  always_comb begin
    w_rd_nxt = '0;
    case (reg_addr_e'(address))
      DATA:    w_rd_nxt[WIDTH-1:0] = w_stable;
      IRQMASK: w_rd_nxt[WIDTH-1:0] = r_mask;
      EDGECAP: w_rd_nxt[WIDTH-1:0] = r_cap;
      default: w_rd_nxt = '0;
    endcase
  end

  // Registered read data and interrupt level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd  <= '0;
      r_irq <= 1'b0;
    end else begin
      r_rd  <= w_rd_nxt;
      r_irq <= |(r_cap & r_mask);
    end
  end

  assign readdata = r_rd;
  assign irq      = r_irq;

endmodule

// File: tb/tb_nios2_system_sw_pio_irq.sv
// Bench for the switch-input PIO: two configurations share one bus and
// input stimulus and are checked every cycle against a behavioural model.
module tb_nios2_system_sw_pio_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs;
  logic        wn;
  logic [1:0]  address;
  logic [31:0] wd;
  logic [9:0]  in_port;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nios2_system_sw_pio_irq #(
    .WIDTH(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs),
    .write_n(wn), .writedata(wd), .in_port(in_port), .readdata(rd0), .irq(irq0)
  );

  nios2_system_sw_pio_irq #(
    .WIDTH(10), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs),
    .write_n(wn), .writedata(wd), .in_port(in_port), .readdata(rd1), .irq(irq1)
  );

  // Model configuration per instance: sync depth, debounce length, edge mode.
  int cfg_s[2] = '{2, 3};
  int cfg_d[2] = '{0, 4};
  int cfg_e[2] = '{0, 2};

  // Behavioural model state.
  logic [9:0]  in_hist[$];
  logic [9:0]  m_stable[2];
  logic [9:0]  m_mask[2];
  logic [9:0]  m_cap[2];
  logic [31:0] m_rd[2];
  logic        m_irq[2];

  // in_port as sampled idx+1 edges ago; zero before reset release.
  function automatic logic [9:0] past(input int idx);
    if (idx < in_hist.size()) return in_hist[idx];
    return '0;
  endfunction

  task automatic model_clear();
    in_hist.delete();
    for (int i = 0; i < 2; i++) begin
      m_stable[i] = '0;
      m_mask[i]   = '0;
      m_cap[i]    = '0;
      m_rd[i]     = '0;
      m_irq[i]    = 1'b0;
    end
  endtask

  // One clock edge: a bit is accepted once the last D synchronised samples
  // all disagree with the current stable value (D=0: follow the sample).
  task automatic model_step();
    logic [9:0] nst, smp, rise, fall, ed, clr;
    logic       all, wr;
    for (int i = 0; i < 2; i++) begin
      nst = m_stable[i];
      if (cfg_d[i] == 0) begin
        nst = past(cfg_s[i] - 1);
      end else begin
        for (int b = 0; b < 10; b++) begin
          all = 1'b1;
          for (int m = 0; m < cfg_d[i]; m++) begin
            smp = past(cfg_s[i] - 1 + m);
            if (smp[b] == m_stable[i][b]) all = 1'b0;
          end
          if (all) nst[b] = ~m_stable[i][b];
        end
      end
      rise = nst & ~m_stable[i];
      fall = ~nst & m_stable[i];
      ed   = (cfg_e[i] == 0) ? rise : (cfg_e[i] == 1) ? fall : (rise | fall);
      wr   = cs && !wn;
      case (address)
        2'd0:    m_rd[i] = {22'b0, m_stable[i]};
        2'd2:    m_rd[i] = {22'b0, m_mask[i]};
        2'd3:    m_rd[i] = {22'b0, m_cap[i]};
        default: m_rd[i] = '0;
      endcase
      m_irq[i] = |(m_cap[i] & m_mask[i]);
      clr = (wr && address == 2'd3) ? wd[9:0] : '0;
      m_cap[i] = (m_cap[i] & ~clr) | ed;
      if (wr && address == 2'd2) m_mask[i] = wd[9:0];
      m_stable[i] = nst;
    end
    in_hist.push_front(in_port);
    if (in_hist.size() > 16) void'(in_hist.pop_back());
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_clear();
      else          model_step();
    end
  end

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    cmp("rd0",  rd0, m_rd[0]);
    cmp("irq0", {31'b0, irq0}, {31'b0, m_irq[0]});
    cmp("rd1",  rd1, m_rd[1]);
    cmp("irq1", {31'b0, irq1}, {31'b0, m_irq[1]});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; wd = d; cs = 1'b1; wn = 1'b0;
    tick();
    cs = 1'b0; wn = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    tick();
  endtask

  task automatic do_reset(input logic [9:0] v);
    reset_n = 1'b0; in_port = v; cs = 1'b0; wn = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1; cs = 1'b0; wn = 1'b1; address = '0; wd = '0; in_port = '0;
    #1 reset_n = 1'b0;
    repeat (3) tick();
    cmp("rst_rd0",  rd0, 32'h0);
    cmp("rst_irq0", {31'b0, irq0}, 32'h0);
    cmp("rst_rd1",  rd1, 32'h0);
    cmp("rst_irq1", {31'b0, irq1}, 32'h0);
    reset_n = 1'b1;

    // DATA after reset, reserved register ignores writes.
    rd(2'd0); rd(2'd0);
    cmp("data_zero", rd0, 32'h0);
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1);
    cmp("rsvd0", rd0, 32'h0);
    cmp("rsvd1", rd1, 32'h0);

    // DATA latency with D=0, SYNC_STAGES=2.
    address = 2'd0; in_port = 10'h2A5;
    repeat (3) tick();
    cmp("data_early", rd0, 32'h0);
    tick();
    cmp("data_2a5", rd0, 32'h0000_02A5);
    repeat (6) tick();
    cmp("data_2a5_db", rd1, 32'h0000_02A5);

    // Rising edge with mask bit 0, then W1C.
    do_reset(10'h000);
    wr(2'd2, 32'h1);
    in_port = 10'h001;
    repeat (10) tick();
    cmp("irq_set0", {31'b0, irq0}, 32'h1);
    cmp("irq_set1", {31'b0, irq1}, 32'h1);
    rd(2'd3);
    cmp("cap_b0", rd0, 32'h1);
    wr(2'd3, 32'h1);
    cmp("irq_still0", {31'b0, irq0}, 32'h1);
    tick();
    cmp("irq_clr0", {31'b0, irq0}, 32'h0);
    cmp("irq_clr1", {31'b0, irq1}, 32'h0);

    // Debounce rejects a 3-cycle pulse and accepts a held level.
    do_reset(10'h000);
    in_port = 10'h008;
    repeat (3) tick();
    in_port = 10'h000;
    repeat (10) tick();
    rd(2'd0);
    cmp("pulse_data1", rd1, 32'h0);
    rd(2'd3);
    cmp("pulse_cap1", rd1, 32'h0);
    in_port = 10'h008;
    repeat (8) tick();
    rd(2'd0);
    cmp("hold_data1", rd1, 32'h8);
    rd(2'd3);
    cmp("hold_cap1", rd1, 32'h8);

    // New edge coincides with W1C: capture wins.
    do_reset(10'h000);
    in_port = 10'h020;
    repeat (10) tick();
    in_port = 10'h000;
    repeat (10) tick();
    in_port = 10'h020;
    repeat (6) tick();
    wr(2'd3, 32'h20);
    rd(2'd3);
    cmp("edge_wins1", rd1 & 32'h20, 32'h20);
    wr(2'd3, 32'h20);
    rd(2'd3);
    cmp("w1c_alone1", rd1 & 32'h20, 32'h0);

    // Asynchronous reset in the middle of a debounce.
    do_reset(10'h000);
    wr(2'd2, 32'h3FF);
    in_port = 10'h3FF;
    repeat (10) tick();
    cmp("irq_all0", {31'b0, irq0}, 32'h1);
    cmp("irq_all1", {31'b0, irq1}, 32'h1);
    rd(2'd3);
    cmp("cap_all0", rd0, 32'h3FF);
    cmp("cap_all1", rd1, 32'h3FF);
    in_port = 10'h155;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    cmp("arst_irq0", {31'b0, irq0}, 32'h0);
    cmp("arst_irq1", {31'b0, irq1}, 32'h0);
    cmp("arst_rd0",  rd0, 32'h0);
    cmp("arst_rd1",  rd1, 32'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    rd(2'd3);
    cmp("arst_cap0", rd0, 32'h0);
    cmp("arst_cap1", rd1, 32'h0);
    rd(2'd2);
    cmp("arst_mask0", rd0, 32'h0);
    cmp("arst_mask1", rd1, 32'h0);
    address = 2'd0;
    repeat (10) tick();
    cmp("arst_data0", rd0, 32'h155);
    cmp("arst_data1", rd1, 32'h155);

    // Randomised traffic, checked every cycle by the compare process.
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 15));
      if (r == 0)      in_port = 10'($urandom);
      else if (r < 3)  in_port[$urandom_range(0, 9)] = ~in_port[$urandom_range(0, 9)];
      cs      = 1'($urandom);
      wn      = 1'($urandom);
      address = 2'($urandom);
      wd      = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
      end
      tick();
    end
    cs = 1'b0; wn = 1'b1;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
